// File: rtl/n_bit_alu_seq.sv
// n_bit_alu_seq: registered WIDTH-bit ALU built from a rippled 1-bit slice
// model. It also has an iterative shift-add unsigned multiplier and a
// start/busy/done handshake.
//
// The ALU path takes two clock edges: one edge captures the operands and the
// next edge writes the outputs. The multiply path takes exactly WIDTH edges
// after start is sampled, one shift-add step per edge.
module n_bit_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mulEn,
  input  logic [3:0]       aluCtl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             carryOut,
  output logic             overflow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t state, state_next;

  // Captured request
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [3:0]         ctl_q;

  // Multiplier datapath
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  // ALU slice chain
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic               add_ovf;
  logic               slt_set;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_cout;
  logic               alu_ovf;

  assign mul_last = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and busy output
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_next = state;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = mulEn ? MUL : ALU;
      end
      ALU: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      MUL: begin
        busy = 1'b1;
        if (mul_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ripple-carry slice chain over the captured operands, plus the op mux
  always_comb begin
    a_s      = op_a ^ {WIDTH{ctl_q[3]}};
    b_s      = op_b ^ {WIDTH{ctl_q[2]}};
    carry    = '0;
    sum      = '0;
    // carry-in of bit 0 follows binvert so that SUB is a + ~b + 1
    carry[0] = ctl_q[2];
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]     = a_s[i] ^ b_s[i] ^ carry[i];
      carry[i+1] = (a_s[i] & b_s[i]) | (carry[i] & (a_s[i] ^ b_s[i]));
    end
    add_ovf  = carry[WIDTH] ^ carry[WIDTH-1];
    // The sign corrected by overflow is the true sign of the full-precision difference.
    slt_set  = sum[WIDTH-1] ^ add_ovf;
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    unique case (ctl_q[1:0])
      2'b00: alu_res = a_s & b_s;
      2'b01: alu_res = a_s | b_s;
      2'b10: begin
        alu_res  = sum;
        alu_cout = carry[WIDTH];
        alu_ovf  = add_ovf;
      end
      default: begin
        alu_res  = {{(WIDTH-1){1'b0}}, slt_set};
        alu_cout = carry[WIDTH];
        alu_ovf  = add_ovf;
      end
    endcase
  end

  // One shift-add step: accumulate the multiplicand when the multiplier LSB is set
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // Operand capture, multiply iteration and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: all datapath registers are reset too, so the outputs read as zero after an aborted multiply.
      op_a     <= '0;
      op_b     <= '0;
      ctl_q    <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      result   <= '0;
      resultHi <= '0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            ctl_q  <= aluCtl;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        ALU: begin
          result   <= alu_res;
          resultHi <= '0;
          carryOut <= alu_cout;
          overflow <= alu_ovf;
          zero     <= (alu_res == '0);
          done     <= 1'b1;
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (mul_last) begin
            result   <= acc_next[WIDTH-1:0];
            resultHi <= acc_next[2*WIDTH-1:WIDTH];
            carryOut <= 1'b0;
            overflow <= (acc_next[2*WIDTH-1:WIDTH] != '0);
            zero     <= (acc_next == '0);
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_n_bit_alu_seq.sv
// Testbench for n_bit_alu_seq at WIDTH=8. The driver pushes the expected
// response and the completion cycle into a scoreboard. A separate monitor
// pops one entry for each done pulse and compares it with the outputs.
module tb_n_bit_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         mulEn;
  logic [3:0]   aluCtl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] resultHi;
  logic         carryOut;
  logic         overflow;
  logic         zero;

  n_bit_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mulEn    (mulEn),
    .aluCtl   (aluCtl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .resultHi (resultHi),
    .carryOut (carryOut),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           due;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   op_id  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model written directly from the operation definitions
  function automatic exp_t model(input bit mul, input logic [3:0] ctl,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] xa, yb;
    int           cin, u, s, sx, sy;
    longint       p;
    e.due = 0;
    e.id  = 0;
    if (mul) begin
      p      = longint'(x) * longint'(y);
      e.res  = W'(p);
      e.hi   = W'(p >> W);
      e.cout = 1'b0;
      e.ovf  = (e.hi != 0);
      e.zero = (p == 0);
    end else begin
      xa  = ctl[3] ? ~x : x;
      yb  = ctl[2] ? ~y : y;
      cin = ctl[2] ? 1 : 0;
      u   = int'(xa) + int'(yb) + cin;
      sx  = $signed(xa);
      sy  = $signed(yb);
      s   = sx + sy + cin;
      e.hi = '0;
      case (ctl[1:0])
        2'b00: begin e.res = xa & yb; e.cout = 1'b0; e.ovf = 1'b0; end
        2'b01: begin e.res = xa | yb; e.cout = 1'b0; e.ovf = 1'b0; end
        default: begin
          e.res  = (ctl[1:0] == 2'b10) ? W'(u) : ((s < 0) ? W'(1) : W'(0));
          e.cout = (u >= (1 << W));
          e.ovf  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        end
      endcase
      e.zero = (e.res == 0);
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("op%0d done_cycle", e.id), 64'(cyc), 64'(e.due));
        check($sformatf("op%0d result", e.id), 64'(result), 64'(e.res));
        check($sformatf("op%0d resultHi", e.id), 64'(resultHi), 64'(e.hi));
        check($sformatf("op%0d carryOut", e.id), 64'(carryOut), 64'(e.cout));
        check($sformatf("op%0d overflow", e.id), 64'(overflow), 64'(e.ovf));
        check($sformatf("op%0d zero", e.id), 64'(zero), 64'(e.zero));
        check($sformatf("op%0d busy_at_done", e.id), 64'(busy), 64'(0));
      end
    end
  end

  // Issue one request from a negedge; returns at the negedge after it was sampled
  task automatic issue(input bit mul, input logic [3:0] ctl,
                       input logic [W-1:0] x, input logic [W-1:0] y, input bit expect_done);
    exp_t e;
    int   guard;
    guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("wait_idle_timeout", 64'(busy), 64'(0));
    start  = 1'b1;
    mulEn  = mul;
    aluCtl = ctl;
    a      = x;
    b      = y;
    if (expect_done) begin
      e     = model(mul, ctl, x, y);
      e.due = cyc + 1 + (mul ? W : 1);
      e.id  = op_id;
      sb.push_back(e);
    end
    op_id++;
    @(negedge clk);
    start  = 1'b0;
    a      = W'($urandom);
    b      = W'($urandom);
    aluCtl = 4'($urandom);
    mulEn  = 1'($urandom);
  endtask

  // Wait for all outstanding expectations to complete
  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"},     64'(busy),     64'(0));
    check({tag, " done"},     64'(done),     64'(0));
    check({tag, " result"},   64'(result),   64'(0));
    check({tag, " resultHi"}, 64'(resultHi), 64'(0));
    check({tag, " carryOut"}, 64'(carryOut), 64'(0));
    check({tag, " overflow"}, 64'(overflow), 64'(0));
    check({tag, " zero"},     64'(zero),     64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: reset must win
    reset  = 1'b1;
    start  = 1'b1;
    mulEn  = 1'b0;
    aluCtl = 4'b0010;
    a      = 8'h11;
    b      = 8'h22;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset busy", 64'(busy), 64'(0));

    // Directed ALU cases, issued back to back
    issue(0, 4'b0010, 8'h7F, 8'h01, 1);  // ADD overflow
    issue(0, 4'b0110, 8'h05, 8'h05, 1);  // SUB -> zero, carry
    issue(0, 4'b0110, 8'h00, 8'h01, 1);  // SUB borrow
    issue(0, 4'b0111, 8'hFE, 8'h03, 1);  // SLT -2 < 3
    issue(0, 4'b0111, 8'h03, 8'hFE, 1);  // SLT 3 < -2 false
    issue(0, 4'b0111, 8'h80, 8'h7F, 1);  // SLT with overflow
    issue(0, 4'b1100, 8'hF0, 8'h0F, 1);  // NOR
    issue(0, 4'b0000, 8'hF0, 8'h3C, 1);  // AND
    issue(0, 4'b0001, 8'hF0, 8'h3C, 1);  // OR
    issue(0, 4'b0010, 8'hFF, 8'h01, 1);  // ADD wrap to zero
    drain();

    // Multiply boundaries
    issue(1, 4'b0000, 8'h00, 8'h5A, 1);
    issue(1, 4'b0000, 8'hFF, 8'hFF, 1);
    issue(1, 4'b0000, 8'h0F, 8'h11, 1);
    drain();

    // Multiply with start pulses while busy (must be ignored)
    issue(1, 4'b0000, 8'hC8, 8'h03, 1);
    for (int i = 0; i < 3; i++) begin
      start  = 1'b1;
      mulEn  = 1'b0;
      aluCtl = 4'b0010;
      a      = W'($urandom);
      b      = W'($urandom);
      @(negedge clk);
      start  = 1'b0;
      @(negedge clk);
    end
    drain();

    // Reset in the middle of a multiply: abort, outputs cleared, no done
    issue(1, 4'b0000, 8'hFF, 8'hFF, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort no_pending", 64'(sb.size()), 64'(0));
    issue(0, 4'b0010, 8'h01, 8'h01, 1);
    drain();

    // Randomized mix of ALU codes and multiplies
    for (int i = 0; i < 150; i++) begin
      issue(($urandom_range(3) == 0), 4'($urandom), W'($urandom), W'($urandom), 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
